fast_square_sweep_ctrl: RTL and testbench

Sweep scheduler for the fast-square baseband comb/decimate datapath. It steps the LO through NUM_STEPS frequency positions and, at each step, resets the comb chain and waits out filter settling, counted in output strobes. It then opens a record window for a fixed number of output strobes. It sits between host control registers and the comb datapath, driving that datapath's reset and the capture path's record enable.

---
 rtl/fast_square_sweep_ctrl.sv | 150 +++++++++++++++
 tb/tb_fast_square_sweep_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_square_sweep_ctrl.sv
// Sweep scheduler for the fast-square comb/decimate datapath: steps the LO through
// NUM_STEPS positions, resets and settles the comb chain, then opens a record window.
module fast_square_sweep_ctrl #(
  parameter int NUM_STEPS      = 5,
  parameter int RESET_CYCLES   = 4,
  parameter int SETTLE_STROBES = 102,
  parameter int RECORD_STROBES = 64,
  parameter int CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic        data_out_strobe,
  output logic        comb_reset,
  output logic        freq_step,
  output logic [2:0]  step_idx,
  output logic        record,
  output logic        busy,
  output logic        sweep_done,
  output logic [15:0] sweep_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_RESET  = 3'd2,
    S_SETTLE = 3'd3,
    S_RECORD = 3'd4,
    S_NEXT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_STROBES - 1);
  localparam logic [CNT_W-1:0] RECORD_LAST = CNT_W'(RECORD_STROBES - 1);
  localparam logic [2:0]       LAST_STEP   = 3'(NUM_STEPS - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  assign state_dbg = state_q;

  // Outputs are assigned together with the state they belong to, so each one is
  // valid in the same cycle its state is current.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      comb_reset  <= 1'b1;
      freq_step   <= 1'b0;
      step_idx    <= 3'd0;
      record      <= 1'b0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      sweep_count <= 16'd0;
    end else begin
      freq_step  <= 1'b0;
      sweep_done <= 1'b0;
      if (stop && state_q != S_IDLE) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        comb_reset <= 1'b1;
        record     <= 1'b0;
        busy       <= 1'b0;
        step_idx   <= 3'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !stop) begin
              state_q    <= S_STEP;
              cnt_q      <= '0;
              step_idx   <= 3'd0;
              freq_step  <= 1'b1;
              busy       <= 1'b1;
              comb_reset <= 1'b1;
            end
          end
          S_STEP: begin
            state_q <= S_RESET;
            cnt_q   <= '0;
          end
          S_RESET: begin
            if (cnt_q == RESET_LAST) begin
              state_q    <= S_SETTLE;
              cnt_q      <= '0;
              comb_reset <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_SETTLE: begin
            if (data_out_strobe) begin
              if (cnt_q == SETTLE_LAST) begin
                state_q <= S_RECORD;
                cnt_q   <= '0;
                record  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_RECORD: begin
            if (data_out_strobe) begin
              if (cnt_q == RECORD_LAST) begin
                state_q <= S_NEXT;
                cnt_q   <= '0;
                record  <= 1'b0;
                if (step_idx == LAST_STEP) begin
                  step_idx    <= 3'd0;
                  sweep_done  <= 1'b1;
                  sweep_count <= sweep_count + 16'd1;
                end
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_NEXT: begin
            // sweep_done is high exactly in the NEXT cycle that closes a sweep.
            if (!sweep_done) begin
              state_q    <= S_STEP;
              step_idx   <= step_idx + 3'd1;
              freq_step  <= 1'b1;
              comb_reset <= 1'b1;
            end else if (continuous) begin
              state_q    <= S_STEP;
              freq_step  <= 1'b1;
              comb_reset <= 1'b1;
            end else begin
              state_q    <= S_IDLE;
              busy       <= 1'b0;
              comb_reset <= 1'b1;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            comb_reset <= 1'b1;
            record     <= 1'b0;
            busy       <= 1'b0;
            step_idx   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Randomized-strobe bench for fast_square_sweep_ctrl; expected traces come from an
// interval-based schedule model built from the sweep timing rules.
module tb_fast_square_sweep_ctrl;
  localparam int NUM_STEPS      = 5;
  localparam int RESET_CYCLES   = 4;
  localparam int SETTLE_STROBES = 3;
  localparam int RECORD_STROBES = 2;
  localparam int CNT_W          = 16;
  localparam int MAXC           = 6000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic        data_out_strobe = 1'b0;
  logic        comb_reset, freq_step, record, busy, sweep_done;
  logic [2:0]  step_idx, state_dbg;
  logic [15:0] sweep_count;

  int checks = 0;
  int errors = 0;

  bit          start_a [MAXC];
  bit          stop_a  [MAXC];
  bit          cont_a  [MAXC];
  bit          strb_a  [MAXC];
  logic [23:0] exp_a   [MAXC];
  logic [23:0] exp_q[$];

  fast_square_sweep_ctrl #(
    .NUM_STEPS(NUM_STEPS), .RESET_CYCLES(RESET_CYCLES), .SETTLE_STROBES(SETTLE_STROBES),
    .RECORD_STROBES(RECORD_STROBES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .continuous(continuous),
    .data_out_strobe(data_out_strobe), .comb_reset(comb_reset), .freq_step(freq_step),
    .step_idx(step_idx), .record(record), .busy(busy), .sweep_done(sweep_done),
    .sweep_count(sweep_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; data_out_strobe = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // {comb_reset, freq_step, step_idx, record, busy, sweep_done, sweep_count}
  function automatic logic [23:0] pack(input bit comb, input bit fsv, input int idx,
                                       input bit rec, input bit bsy, input bit done, input int cnt);
    logic [2:0]  i3;
    logic [15:0] c16;
    i3  = idx[2:0];
    c16 = cnt[15:0];
    return {comb, fsv, i3, rec, bsy, done, c16};
  endfunction

  function automatic logic [23:0] observe();
    return {comb_reset, freq_step, step_idx, record, busy, sweep_done, sweep_count};
  endfunction

  // stimulus tables
  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      start_a[i] = 1'b0; stop_a[i] = 1'b0; cont_a[i] = 1'b0; strb_a[i] = 1'b0;
    end
  endtask

  task automatic gen_strobes(input int first);
    int k;
    k = first;
    while (k < MAXC) begin
      strb_a[k] = 1'b1;
      k += $urandom_range(25, 40);
    end
  endtask

  // reference schedule model
  function automatic int nth_strobe(input int from, input int n);
    int left;
    left = n;
    for (int cy = from; cy < MAXC; cy++) begin
      if (strb_a[cy]) begin
        left--;
        if (left == 0) return cy;
      end
    end
    return MAXC;
  endfunction

  task automatic span(input int a, input int b, input bit comb, input bit fsv, input int idx,
                      input bit rec, input bit done, input int cnt, output int ab);
    ab = -1;
    for (int cy = a; cy <= b && cy < MAXC; cy++) begin
      exp_a[cy] = pack(comb, fsv, idx, rec, 1'b1, done, cnt);
      if (stop_a[cy]) begin
        ab = cy;
        return;
      end
    end
  endtask

  task automatic run_model();
    int c, cnt, s, fs, c3, r2, n, ab;
    bit last;
    c = 0; cnt = 0;
    while (c < MAXC) begin
      exp_a[c] = pack(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, cnt);
      if (start_a[c] && !stop_a[c]) begin
        fs = c + 1; s = 0; ab = -1;
        while (fs < MAXC) begin
          span(fs, fs, 1'b1, 1'b1, s, 1'b0, 1'b0, cnt, ab);
          if (ab >= 0) break;
          span(fs + 1, fs + RESET_CYCLES, 1'b1, 1'b0, s, 1'b0, 1'b0, cnt, ab);
          if (ab >= 0) break;
          c3 = nth_strobe(fs + RESET_CYCLES + 1, SETTLE_STROBES);
          span(fs + RESET_CYCLES + 1, c3, 1'b0, 1'b0, s, 1'b0, 1'b0, cnt, ab);
          if (ab >= 0) break;
          r2 = (c3 >= MAXC) ? MAXC : nth_strobe(c3 + 1, RECORD_STROBES);
          span(c3 + 1, r2, 1'b0, 1'b0, s, 1'b1, 1'b0, cnt, ab);
          if (ab >= 0) break;
          n = r2 + 1;
          if (n >= MAXC) begin ab = MAXC; break; end
          last = (s == NUM_STEPS - 1);
          if (last) cnt = (cnt + 1) % 65536;
          span(n, n, 1'b0, 1'b0, last ? 0 : s, 1'b0, last, cnt, ab);
          if (ab >= 0) break;
          if (!last) s++;
          else if (cont_a[n]) s = 0;
          else begin ab = n; break; end
          fs = n + 1;
        end
        if (ab < 0) ab = MAXC;
        c = ab + 1;
      end else begin
        c++;
      end
    end
  endtask

  // driver + scoreboard: compares every cycle until the first divergence
  task automatic run_trace(input string name, input int ncyc, output int fs_seen,
                           output int rec_strb);
    logic [23:0] exp_v, obs;
    bit bad;
    bad = 1'b0; fs_seen = 0; rec_strb = 0;
    exp_q.delete();
    for (int i = 0; i < ncyc; i++) exp_q.push_back(exp_a[i]);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock); #1;
      start = start_a[c]; stop = stop_a[c]; continuous = cont_a[c]; data_out_strobe = strb_a[c];
      @(negedge clock);
      exp_v = exp_q.pop_front();
      obs   = observe();
      if (freq_step) fs_seen++;
      if (record && data_out_strobe) rec_strb++;
      if (!bad) begin
        checks++;
        if (obs !== exp_v) begin
          errors++; bad = 1'b1;
          $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp_v);
        end
      end
    end
    start = 1'b0; stop = 1'b0; continuous = 1'b0; data_out_strobe = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    int fsn, rsn;
    reset_n = 1'b0; data_out_strobe = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (observe() !== pack(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0)) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", observe(),
               pack(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0));
    end
    clear_stim();
    gen_strobes($urandom_range(0, 20));
    run_model();
    run_trace("reset_idle", 300, fsn, rsn);
    check_int("idle_freq_steps", fsn, 0);
  endtask

  task automatic test_single_sweep();
    int fsn, rsn;
    clear_stim();
    gen_strobes($urandom_range(3, 30));
    start_a[$urandom_range(5, 20)] = 1'b1;
    run_model();
    run_trace("single_sweep", 1500, fsn, rsn);
    check_int("single_freq_steps", fsn, NUM_STEPS);
    check_int("single_record_strobes", rsn, NUM_STEPS * RECORD_STROBES);
    check_int("single_sweep_count", sweep_count, 1);
    check_int("single_busy_end", busy, 0);
  endtask

  task automatic test_continuous();
    int fsn, rsn, nd, d3;
    clear_stim();
    gen_strobes($urandom_range(3, 30));
    start_a[10] = 1'b1;
    for (int i = 0; i < MAXC; i++) cont_a[i] = 1'b1;
    run_model();
    nd = 0; d3 = -1;
    for (int i = 0; i < MAXC; i++) begin
      if (exp_a[i][16]) begin
        nd++;
        if (nd == 3 && d3 < 0) d3 = i;
      end
    end
    if (d3 >= 0) for (int i = d3 + 100; i < MAXC; i++) cont_a[i] = 1'b0;
    run_model();
    run_trace("continuous", MAXC, fsn, rsn);
    check_int("cont_sweep_count", sweep_count, 4);
    check_int("cont_freq_steps", fsn, 4 * NUM_STEPS);
    check_int("cont_busy_end", busy, 0);
  endtask

  task automatic test_abort();
    int fsn, rsn, ca;
    clear_stim();
    gen_strobes($urandom_range(3, 30));
    start_a[8] = 1'b1;
    run_model();
    ca = -1;
    for (int i = 0; i < MAXC && ca < 0; i++)
      if (exp_a[i][18] && exp_a[i][21:19] == 3'd2 && strb_a[i]) ca = i;
    if (ca >= 0) begin
      stop_a[ca] = 1'b1;
      start_a[ca + 40] = 1'b1;
    end
    run_model();
    run_trace("abort", 3000, fsn, rsn);
    check_int("abort_freq_steps", fsn, 3 + NUM_STEPS);
    check_int("abort_record_strobes", rsn, 2 * RECORD_STROBES + 1 + NUM_STEPS * RECORD_STROBES);
    check_int("abort_sweep_count", sweep_count, 1);
  endtask

  task automatic test_collisions();
    int fsn, rsn;
    clear_stim();
    start_a[10] = 1'b1; stop_a[10] = 1'b1;
    start_a[30] = 1'b1;
    strb_a[31] = 1'b1;
    strb_a[33] = 1'b1;
    gen_strobes(60 + $urandom_range(0, 10));
    run_model();
    run_trace("collisions", 1500, fsn, rsn);
    check_int("collide_freq_steps", fsn, NUM_STEPS);
    check_int("collide_sweep_count", sweep_count, 1);
  endtask

  task automatic test_async_reset();
    int c;
    bit seen;
    do_reset();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    c = 0; seen = 1'b0;
    while (!seen && c < 3000) begin
      @(posedge clock); #1;
      data_out_strobe = (c % 33 == 0);
      c++;
      @(negedge clock);
      if (record) seen = 1'b1;
    end
    check_int("async_reach_record", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (observe() !== pack(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0)) begin
      errors++;
      $display("FAIL async_reset_values: got %h expected %h", observe(),
               pack(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0));
    end
    data_out_strobe = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    checks++;
    if (observe() !== pack(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0)) begin
      errors++;
      $display("FAIL async_restart_step: got %h expected %h", observe(),
               pack(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0));
    end
    @(negedge clock);
    checks++;
    if (observe() !== pack(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0)) begin
      errors++;
      $display("FAIL async_restart_reset: got %h expected %h", observe(),
               pack(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_continuous();
    test_abort();
    test_collisions();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
